// File: rtl/amx_pkg.sv
// Shared types, defaults and helpers for the AMX streaming dot-product core.
// Build option: AMX_SAT_EN selects saturating accumulation in amx_mac.
package amx_pkg;

  localparam int AMX_DATA_W = 6;
  localparam int AMX_LEN    = 4;
  localparam int AMX_ACC_W  = 16;
  localparam int AMX_OUT_W  = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_A   = 2'd0;
  localparam state_t S_B   = 2'd1;
  localparam state_t S_OUT = 2'd2;

  // Output beats needed to carry one accumulator value.
  function automatic int nbeats(input int acc_w, input int out_w);
    return (acc_w + out_w - 1) / out_w;
  endfunction

  // Counter width that is never zero, even for a count of one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/amx_mac.sv
// Registered multiply-accumulate for the AMX dot-product core.
// AMX_SAT_EN defined: clamp to all-ones on overflow with sticky ovf; otherwise wrap, ovf=0.
module amx_mac
  import amx_pkg::*;
#(
  parameter int DATA_W = AMX_DATA_W,
  parameter int ACC_W  = AMX_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              en,
  input  logic              clr,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  localparam int PW = 2 * DATA_W;

  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;

  assign prod = PW'(a) * PW'(b);
  assign acc  = acc_reg;

`ifdef AMX_SAT_EN
  // One extra bit above the wider of product/accumulator exposes the true carry.
  localparam int SW = ((PW > ACC_W) ? PW : ACC_W) + 1;

  logic [SW-1:0] sum_wide;
  logic          sum_over;
  logic          ovf_reg;
  logic          ovf_next;

  always_comb begin
    sum_wide = SW'(acc_reg) + SW'(prod);
    sum_over = |(sum_wide >> ACC_W);
    acc_next = acc_reg;
    ovf_next = ovf_reg;
    if (clr) begin
      acc_next = '0;
      ovf_next = 1'b0;
    end else if (en) begin
      if (sum_over) begin
        acc_next = '1;
        ovf_next = 1'b1;
      end else begin
        acc_next = sum_wide[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_next;
    end
  end

  assign ovf = ovf_reg;
`else
  always_comb begin
    acc_next = acc_reg;
    if (clr) begin
      acc_next = '0;
    end else if (en) begin
      acc_next = acc_reg + ACC_W'(prod);
    end
  end

  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end

endmodule

// File: rtl/amx_dot_core.sv
// Streaming dot-product engine: LEN (a,b) pairs in, ACC_W-bit result out as OUT_W-bit beats, LSB first.
// Build option: AMX_SAT_EN enables saturating accumulation and the sticky ovf flag.
module amx_dot_core
  import amx_pkg::*;
#(
  parameter int DATA_W = AMX_DATA_W,
  parameter int LEN    = AMX_LEN,
  parameter int ACC_W  = AMX_ACC_W,
  parameter int OUT_W  = AMX_OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              ovf
);

  localparam int NB  = nbeats(ACC_W, OUT_W);
  localparam int PCW = cnt_w(LEN);
  localparam int BCW = cnt_w(NB);

  state_t            state_reg;
  state_t            state_next;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] a_next;
  logic [PCW-1:0]    pair_cnt_reg;
  logic [PCW-1:0]    pair_cnt_next;
  logic [BCW-1:0]    beat_cnt_reg;
  logic [BCW-1:0]    beat_cnt_next;

  logic                in_xfer;
  logic                out_xfer;
  logic                last_beat;
  logic                mac_en;
  logic                mac_clr;
  logic [ACC_W-1:0]    acc;
  logic [NB*OUT_W-1:0] acc_pad;
  logic [OUT_W-1:0]    beats [NB];

  assign in_ready  = (state_reg != S_OUT);
  assign out_valid = (state_reg == S_OUT);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign last_beat = (beat_cnt_reg == BCW'(NB - 1));
  assign out_last  = out_valid && last_beat;

  // Zero-fill above ACC_W so the final beat's unused upper bits read as 0.
  always_comb begin
    acc_pad            = '0;
    acc_pad[ACC_W-1:0] = acc;
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_beat
    assign beats[gi] = acc_pad[gi*OUT_W +: OUT_W];
  end

  assign data_out = out_valid ? beats[beat_cnt_reg] : '0;

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    pair_cnt_next = pair_cnt_reg;
    beat_cnt_next = beat_cnt_reg;
    mac_en        = 1'b0;
    mac_clr       = 1'b0;
    case (state_reg)
      S_A: begin
        if (in_xfer) begin
          a_next     = data_in;
          state_next = S_B;
        end
      end
      S_B: begin
        if (in_xfer) begin
          mac_en = 1'b1;
          if (pair_cnt_reg == PCW'(LEN - 1)) begin
            pair_cnt_next = '0;
            state_next    = S_OUT;
          end else begin
            pair_cnt_next = pair_cnt_reg + 1'b1;
            state_next    = S_A;
          end
        end
      end
      S_OUT: begin
        if (out_xfer) begin
          if (last_beat) begin
            beat_cnt_next = '0;
            mac_clr       = 1'b1;
            state_next    = S_A;
          end else begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = S_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_A;
      a_reg        <= '0;
      pair_cnt_reg <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      pair_cnt_reg <= pair_cnt_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // b arrives on data_in during S_B, paired with the a latched in S_A.
  amx_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .a  (a_reg),
    .b  (data_in),
    .en (mac_en),
    .clr(mac_clr),
    .acc(acc),
    .ovf(ovf)
  );

endmodule

// File: tb/tb_amx_dot_core.sv
// Self-checking bench for amx_dot_core: vector table plus scoreboard, two instances (ACC_W=16 and 12).
// Expectations for the ACC_W=12 overflow vector follow AMX_SAT_EN.
module tb_amx_dot_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] data_in   [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] data_out  [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic       out_last  [2];
  logic       ovf       [2];

  always #5 clk = ~clk;

  amx_dot_core #(.DATA_W(6), .LEN(4), .ACC_W(16), .OUT_W(8)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_out(data_out[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_last(out_last[0]), .ovf(ovf[0])
  );

  amx_dot_core #(.DATA_W(6), .LEN(4), .ACC_W(12), .OUT_W(8)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_out(data_out[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_last(out_last[1]), .ovf(ovf[1])
  );

  typedef struct {
    string           name;
    int              sel;
    logic [3:0][5:0] a;
    logic [3:0][5:0] b;
    int              stall;
    bit              gap;
    logic [7:0]      e0;
    logic [7:0]      e1;
    logic            eovf;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       ovf;
  } exp_t;

  exp_t sbq [2][$];
  exp_t mon_e;
  vec_t vecs [9];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input string nm, input int sel, input logic [3:0][5:0] a,
                              input logic [3:0][5:0] b, input int stall, input bit gap,
                              input logic [7:0] e0, input logic [7:0] e1, input logic eovf);
    vec_t v;
    v.name = nm; v.sel = sel; v.a = a; v.b = b; v.stall = stall; v.gap = gap;
    v.e0 = e0; v.e1 = e1; v.eovf = eovf;
    return v;
  endfunction

  function automatic int dot(input logic [3:0][5:0] a, input logic [3:0][5:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(a[i]) * int'(b[i]);
    return s;
  endfunction

  // Scoreboard: every accepted beat must match the next expected entry.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (!rst && out_valid[s] === 1'b1 && out_ready[s] === 1'b1) begin
        if (sbq[s].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat dut%0d actual=0x%0h required=none", s, data_out[s]);
        end else begin
          mon_e = sbq[s].pop_front();
          $display("beat dut%0d data=0x%02h last=%0b ovf=%0b", s, data_out[s], out_last[s], ovf[s]);
          check($sformatf("beat_data_dut%0d", s), 32'(data_out[s]), 32'(mon_e.data));
          check($sformatf("beat_last_dut%0d", s), 32'(out_last[s]), 32'(mon_e.last));
          check($sformatf("beat_ovf_dut%0d", s), 32'(ovf[s]), 32'(mon_e.ovf));
        end
      end
      if (!rst && out_valid[s] === 1'b1)
        check($sformatf("in_ready_in_out_dut%0d", s), 32'(in_ready[s]), 32'd0);
    end
  end

  task automatic push_word(input int s, input logic [5:0] val, input bit gap);
    int n = 0;
    if (gap) begin
      in_valid[s] = 1'b0;
      @(posedge clk); #1;
    end
    in_valid[s] = 1'b1;
    data_in[s]  = val;
    while (in_ready[s] !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready[s] !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout dut%0d actual=0 required=1", s);
    end
    @(posedge clk); #1;
    in_valid[s] = 1'b0;
  endtask

  task automatic wait_drain(input int s, input string nm);
    int n = 0;
    while (out_valid[s] === 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_drain_timeout"}, 32'(out_valid[s]), 32'd0);
    check({nm, "_in_ready_after"}, 32'(in_ready[s]), 32'd1);
    check({nm, "_ovf_after"}, 32'(ovf[s]), 32'd0);
    check({nm, "_sb_empty"}, 32'(sbq[s].size()), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int s = v.sel;
    sbq[s].push_back('{data: v.e0, last: 1'b0, ovf: v.eovf});
    sbq[s].push_back('{data: v.e1, last: 1'b1, ovf: v.eovf});
    out_ready[s] = (v.stall == 0);
    for (int i = 0; i < 4; i++) begin
      push_word(s, v.a[i], v.gap);
      push_word(s, v.b[i], v.gap);
    end
    check({v.name, "_latency"}, 32'(out_valid[s]), 32'd1);
    for (int k = 0; k < v.stall; k++) begin
      check({v.name, "_hold_data"}, 32'(data_out[s]), 32'(v.e0));
      check({v.name, "_hold_last"}, 32'(out_last[s]), 32'd0);
      @(posedge clk); #1;
    end
    out_ready[s] = 1'b1;
    wait_drain(s, v.name);
    $display("vec %s dut%0d expected 0x%02h 0x%02h ovf=%0b", v.name, s, v.e0, v.e1, v.eovf);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_reset(input int s, input string nm);
    check({nm, "_in_ready"}, 32'(in_ready[s]), 32'd1);
    check({nm, "_out_valid"}, 32'(out_valid[s]), 32'd0);
    check({nm, "_data_out"}, 32'(data_out[s]), 32'd0);
    check({nm, "_out_last"}, 32'(out_last[s]), 32'd0);
    check({nm, "_ovf"}, 32'(ovf[s]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0][5:0] ra;
    logic [3:0][5:0] rb;
    int              r;

    vecs[0] = mk("t1_basic", 0, {6'd4, 6'd3, 6'd2, 6'd1}, {6'd8, 6'd7, 6'd6, 6'd5}, 0, 0,
                 8'h46, 8'h00, 1'b0);
    vecs[1] = mk("t2_max", 0, {4{6'd63}}, {4{6'd63}}, 0, 0, 8'h04, 8'h3E, 1'b0);
    vecs[2] = mk("t3_backpressure", 0, {4{6'd63}}, {4{6'd63}}, 3, 0, 8'h04, 8'h3E, 1'b0);
    vecs[3] = mk("t6_gappy", 0, {6'd4, 6'd3, 6'd2, 6'd1}, {6'd8, 6'd7, 6'd6, 6'd5}, 0, 1,
                 8'h46, 8'h00, 1'b0);
`ifdef AMX_SAT_EN
    vecs[4] = mk("t5_acc12_max", 1, {4{6'd63}}, {4{6'd63}}, 0, 0, 8'hFF, 8'h0F, 1'b1);
`else
    vecs[4] = mk("t5_acc12_max", 1, {4{6'd63}}, {4{6'd63}}, 0, 0, 8'h04, 8'h0E, 1'b0);
`endif
    vecs[5] = mk("t5_acc12_after", 1, {6'd4, 6'd3, 6'd2, 6'd1}, {6'd8, 6'd7, 6'd6, 6'd5}, 0, 0,
                 8'h46, 8'h00, 1'b0);
    for (int i = 6; i < 9; i++) begin
      for (int j = 0; j < 4; j++) begin
        ra[j] = 6'($urandom_range(0, 63));
        rb[j] = 6'($urandom_range(0, 63));
      end
      r = dot(ra, rb);
      vecs[i] = mk($sformatf("rand%0d", i), 0, ra, rb, (i == 7) ? 2 : 0, (i == 8),
                   r[7:0], r[15:8], 1'b0);
    end

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      data_in[s]   = '0;
      in_valid[s]  = 1'b0;
      out_ready[s] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset(0, "reset0");
    check_reset(1, "reset1");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset partway through loading: three transfers then reset.
    out_ready[0] = 1'b1;
    push_word(0, 6'd1, 0);
    push_word(0, 6'd5, 0);
    push_word(0, 6'd2, 0);
    do_reset();
    check_reset(0, "rst_midload");

    // Reset while a result is stalled on the output.
    out_ready[0] = 1'b0;
    for (int i = 0; i < 8; i++) push_word(0, 6'd63, 0);
    check("rst_midout_valid", 32'(out_valid[0]), 32'd1);
    @(posedge clk); #1;
    do_reset();
    check_reset(0, "rst_midout");
    out_ready[0] = 1'b1;
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
